// File: rtl/la_iopwrseq_pkg.sv
// Shared types for the IO-ring power sequencer: state encodings and the
// pad-control vector driven in each state.
package la_iopwrseq_pkg;

  typedef enum logic [3:0] {
    ST_OFF      = 4'd0,
    ST_DEBOUNCE = 4'd1,
    ST_SETTLE   = 4'd2,
    ST_EN_H     = 4'd3,
    ST_EN_VDDIO = 4'd4,
    ST_READY    = 4'd5,
    ST_PD_HOLD  = 4'd6,
    ST_PD_VDDIO = 4'd7,
    ST_FAULT    = 4'd8
  } state_t;

  typedef struct packed {
    logic en_h;
    logic en_vddio;
    logic hold_n;
    logic ready;
  } pad_ctl_t;

  localparam pad_ctl_t CTL_SAFE  = 4'b0000;
  localparam pad_ctl_t CTL_H     = 4'b1000;
  localparam pad_ctl_t CTL_VDDIO = 4'b1100;
  localparam pad_ctl_t CTL_READY = 4'b1111;

  function automatic pad_ctl_t ctl_of(input state_t s);
    pad_ctl_t c;
    c = CTL_SAFE;
    case (s)
      ST_EN_H,     ST_PD_VDDIO: c = CTL_H;
      ST_EN_VDDIO, ST_PD_HOLD:  c = CTL_VDDIO;
      ST_READY:                 c = CTL_READY;
      default:                  c = CTL_SAFE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/la_iopwrseq_sync.sv
// Two-flop synchronizer for an asynchronous supply-good level.
module la_iopwrseq_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/la_iopwrseq.sv
// IO-ring power-up/down sequencer. Define LA_IOPWRSEQ_STATUS_EN to add the
// sticky fault flag and saturating fault counter.
module la_iopwrseq
  import la_iopwrseq_pkg::*;
#(
  parameter int DEBOUNCE      = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int STEP_CYCLES   = 8,
  parameter int CW            = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vddio_ok,
  input  logic       vdd_ok,
  input  logic       req_off,
`ifdef LA_IOPWRSEQ_STATUS_EN
  input  logic       fault_clr,
  output logic       fault_sticky,
  output logic [7:0] fault_cnt,
`endif
  output logic       io_enable_h,
  output logic       io_enable_vddio,
  output logic       io_hold_n,
  output logic       pwr_ready,
  output logic [3:0] state
);

  localparam logic [CW-1:0] LD_DB   = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] LD_SET  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] LD_STEP = CW'(STEP_CYCLES - 1);

  logic [1:0] ok_raw, ok_sync;
  logic       good;

  assign ok_raw = {vdd_ok, vddio_ok};

  for (genvar i = 0; i < 2; i++) begin : g_sync
    la_iopwrseq_sync u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (ok_raw[i]),
      .q    (ok_sync[i])
    );
  end

  assign good = &ok_sync;

  state_t        cur, nxt;
  logic [CW-1:0] cnt, ld_val;
  logic          ld, expired;
  pad_ctl_t      ctl;

  assign expired = (cnt == '0);

  // Priority in every powered state: supply loss, then req_off, then expiry.
  always_comb begin
    nxt    = cur;
    ld     = 1'b0;
    ld_val = '0;
    case (cur)
      ST_OFF: begin
        if (good && !req_off) begin
          nxt = ST_DEBOUNCE; ld = 1'b1; ld_val = LD_DB;
        end
      end
      ST_DEBOUNCE: begin
        if (!good || req_off) begin
          nxt = ST_OFF; ld = 1'b1;
        end else if (expired) begin
          nxt = ST_SETTLE; ld = 1'b1; ld_val = LD_SET;
        end
      end
      ST_SETTLE: begin
        if (!good || req_off) begin
          nxt = ST_OFF; ld = 1'b1;
        end else if (expired) begin
          nxt = ST_EN_H; ld = 1'b1; ld_val = LD_STEP;
        end
      end
      ST_EN_H: begin
        if (!good) begin
          nxt = ST_FAULT; ld = 1'b1; ld_val = LD_SET;
        end else if (req_off) begin
          nxt = ST_PD_HOLD; ld = 1'b1; ld_val = LD_STEP;
        end else if (expired) begin
          nxt = ST_EN_VDDIO; ld = 1'b1; ld_val = LD_STEP;
        end
      end
      ST_EN_VDDIO: begin
        if (!good) begin
          nxt = ST_FAULT; ld = 1'b1; ld_val = LD_SET;
        end else if (req_off) begin
          nxt = ST_PD_HOLD; ld = 1'b1; ld_val = LD_STEP;
        end else if (expired) begin
          nxt = ST_READY; ld = 1'b1;
        end
      end
      ST_READY: begin
        if (!good) begin
          nxt = ST_FAULT; ld = 1'b1; ld_val = LD_SET;
        end else if (req_off) begin
          nxt = ST_PD_HOLD; ld = 1'b1; ld_val = LD_STEP;
        end
      end
      ST_PD_HOLD: begin
        if (!good) begin
          nxt = ST_FAULT; ld = 1'b1; ld_val = LD_SET;
        end else if (expired) begin
          nxt = ST_PD_VDDIO; ld = 1'b1; ld_val = LD_STEP;
        end
      end
      ST_PD_VDDIO: begin
        if (!good) begin
          nxt = ST_FAULT; ld = 1'b1; ld_val = LD_SET;
        end else if (expired) begin
          nxt = ST_OFF; ld = 1'b1;
        end
      end
      ST_FAULT: begin
        if (expired) begin
          nxt = ST_OFF; ld = 1'b1;
        end
      end
      default: begin
        nxt = ST_OFF; ld = 1'b1;
      end
    endcase
  end

  // Pad controls are registered off the next state so they change on the
  // same edge as the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= ST_OFF;
      cnt <= '0;
      ctl <= CTL_SAFE;
    end else begin
      cur <= nxt;
      ctl <= ctl_of(nxt);
      if (ld)            cnt <= ld_val;
      else if (!expired) cnt <= cnt - 1'b1;
    end
  end

  assign io_enable_h     = ctl.en_h;
  assign io_enable_vddio = ctl.en_vddio;
  assign io_hold_n       = ctl.hold_n;
  assign pwr_ready       = ctl.ready;
  assign state           = cur;

`ifdef LA_IOPWRSEQ_STATUS_EN
  logic fault_entry;
  assign fault_entry = (nxt == ST_FAULT) && (cur != ST_FAULT);

  // A fault entry coincident with a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_sticky <= 1'b0;
      fault_cnt    <= '0;
    end else if (fault_entry) begin
      fault_sticky <= 1'b1;
      if (fault_clr)               fault_cnt <= 8'd1;
      else if (fault_cnt != 8'hff) fault_cnt <= fault_cnt + 8'd1;
    end else if (fault_clr) begin
      fault_sticky <= 1'b0;
      fault_cnt    <= '0;
    end
  end
`endif

endmodule
